// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port Mem between the fetch and data ports.
// Issue/wait/done sequencing with a DataReady timeout and fetch anti-starvation.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        If_Req,
  input  logic [29:0] If_Addr,
  output logic        If_Ack,
  output logic [31:0] If_Data,
  output logic        If_Err,
  input  logic        Dm_Req,
  input  logic        Dm_RW,
  input  logic [3:0]  Dm_BE,
  input  logic [29:0] Dm_Addr,
  input  logic [31:0] Dm_WData,
  output logic        Dm_Ack,
  output logic [31:0] Dm_RData,
  output logic        Dm_Err,
  output logic        Mem_CS,
  output logic        Mem_RW,
  output logic [3:0]  Mem_BE,
  output logic [29:0] Mem_Addr,
  output logic [31:0] Mem_DataIn,
  input  logic [31:0] Mem_DataOut,
  input  logic        Mem_DataReady
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
  localparam logic [7:0] TLIM = 8'(TIMEOUT);

  state_t      state;
  logic        ownerIf;
  logic        rwQ;
  logic        errQ;
  logic [29:0] addrQ;
  logic [3:0]  beQ;
  logic [31:0] wdataQ;
  logic [3:0]  starveCnt;
  logic [7:0]  waitCnt;
  logic        grantIf;
  logic        grantDm;

  // Arbitration: data wins unless fetch is alone or has been starved.
  always_comb begin
    grantIf = If_Req && (!Dm_Req || (starveCnt == SLIM));
    grantDm = Dm_Req && !grantIf;
  end

  // Mem side and acks decoded from state, so reset removes RW at once.
  always_comb begin
    Mem_CS     = (state == ISSUE) || (state == WAIT);
    Mem_RW     = (state == ISSUE) && rwQ;
    Mem_Addr   = Mem_CS ? addrQ : '0;
    Mem_BE     = Mem_CS ? beQ : '0;
    Mem_DataIn = Mem_RW ? wdataQ : '0;
    If_Ack     = (state == DONE) && ownerIf;
    Dm_Ack     = (state == DONE) && !ownerIf;
    If_Err     = If_Ack && errQ;
    Dm_Err     = Dm_Ack && errQ;
  end

  // Access sequencer: grant/latch, issue, wait with timeout, complete.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      ownerIf   <= 1'b0;
      rwQ       <= 1'b0;
      errQ      <= 1'b0;
      addrQ     <= '0;
      beQ       <= '0;
      wdataQ    <= '0;
      starveCnt <= '0;
      waitCnt   <= '0;
      If_Data   <= '0;
      Dm_RData  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grantIf) begin
            ownerIf   <= 1'b1;
            addrQ     <= If_Addr;
            beQ       <= 4'b1111;
            rwQ       <= 1'b0;
            wdataQ    <= '0;
            starveCnt <= '0;
            state     <= ISSUE;
          end else if (grantDm) begin
            ownerIf <= 1'b0;
            addrQ   <= Dm_Addr;
            beQ     <= Dm_BE;
            rwQ     <= Dm_RW;
            wdataQ  <= Dm_WData;
            state   <= ISSUE;
            if (!If_Req) begin
              starveCnt <= '0;
            end else if (starveCnt != SLIM) begin
              starveCnt <= starveCnt + 4'd1;
            end
          end else begin
            starveCnt <= '0;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (Mem_DataReady) begin
            if (!rwQ) begin
              if (ownerIf) begin
                If_Data <= Mem_DataOut;
              end else begin
                Dm_RData <= Mem_DataOut;
              end
            end
            state <= DONE;
          end else if (waitCnt == TLIM) begin
            errQ <= 1'b1;
            if (!rwQ) begin
              if (ownerIf) begin
                If_Data <= '0;
              end else begin
                Dm_RData <= '0;
              end
            end
            state <= DONE;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        DONE: begin
          waitCnt <= '0;
          errQ    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, corner sequences and randomized traffic
// against a behavioural Mem model and a reference memory/arbiter model.
module tb_mem_arbiter;

  localparam int SL = 4;
  localparam int TO = 15;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        If_Req;
  logic [29:0] If_Addr;
  logic        If_Ack;
  logic [31:0] If_Data;
  logic        If_Err;
  logic        Dm_Req;
  logic        Dm_RW;
  logic [3:0]  Dm_BE;
  logic [29:0] Dm_Addr;
  logic [31:0] Dm_WData;
  logic        Dm_Ack;
  logic [31:0] Dm_RData;
  logic        Dm_Err;
  logic        Mem_CS;
  logic        Mem_RW;
  logic [3:0]  Mem_BE;
  logic [29:0] Mem_Addr;
  logic [31:0] Mem_DataIn;
  logic [31:0] Mem_DataOut;
  logic        Mem_DataReady;

  always #5 Clk = ~Clk;

  mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .If_Req(If_Req), .If_Addr(If_Addr), .If_Ack(If_Ack),
    .If_Data(If_Data), .If_Err(If_Err),
    .Dm_Req(Dm_Req), .Dm_RW(Dm_RW), .Dm_BE(Dm_BE),
    .Dm_Addr(Dm_Addr), .Dm_WData(Dm_WData), .Dm_Ack(Dm_Ack),
    .Dm_RData(Dm_RData), .Dm_Err(Dm_Err),
    .Mem_CS(Mem_CS), .Mem_RW(Mem_RW), .Mem_BE(Mem_BE),
    .Mem_Addr(Mem_Addr), .Mem_DataIn(Mem_DataIn),
    .Mem_DataOut(Mem_DataOut), .Mem_DataReady(Mem_DataReady)
  );

  function automatic logic [31:0] initVal(int i);
    case (i)
      5:       return 32'h55555555;
      7:       return 32'h3C08BFC0;
      21:      return 32'hAAAAAAAA;
      default: return (32'h9E3779B9 * 32'(i)) + 32'h1234;
    endcase
  endfunction

  // Mem model: sync read, writes whenever RW is high, stallable DataReady.
  logic [31:0] memArr [64];
  logic        memInit;
  int          csCnt = 0;
  int          stall = 0;
  assign Mem_DataReady = (csCnt > stall);

  always @(posedge Clk) begin
    csCnt <= Mem_CS ? csCnt + 1 : 0;
    if (memInit) begin
      for (int i = 0; i < 64; i++) memArr[i] <= initVal(i);
    end else if (Mem_RW) begin
      for (int b = 0; b < 4; b++)
        if (Mem_BE[b])
          memArr[Mem_Addr[5:0]][8*b+:8] <= Mem_DataIn[8*b+:8];
    end
    Mem_DataOut <= memArr[Mem_Addr[5:0]];
  end

  logic [31:0] refMem [64];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic refWrite(input logic [29:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (be[b]) refMem[a[5:0]][8*b+:8] = wd[8*b+:8];
  endtask

  task automatic waitAck(output int n, output bit gi, output bit gd,
                         output int rwc);
    n = 0; gi = 0; gd = 0; rwc = 0;
    while (!gi && !gd && n < 400) begin
      @(posedge Clk); #1;
      n++;
      if (Mem_RW) rwc++;
      gi = If_Ack;
      gd = Dm_Ack;
    end
    if (!gi && !gd) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: no Ack after %0d cycles, expected one", n);
    end
  endtask

  typedef struct {
    bit          isIf;
    bit          rw;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wd;
    int          stl;
    int          expN;
    bit          chkD;
    logic [31:0] expD;
    bit          expE;
    int          expRw;
  } vec_t;

  function automatic vec_t mk(bit isIf, bit rw, logic [3:0] be,
      logic [29:0] addr, logic [31:0] wd, int stl, int expN, bit chkD,
      logic [31:0] expD, bit expE, int expRw);
    vec_t v;
    v.isIf = isIf; v.rw = rw; v.be = be; v.addr = addr; v.wd = wd;
    v.stl = stl; v.expN = expN; v.chkD = chkD; v.expD = expD;
    v.expE = expE; v.expRw = expRw;
    return v;
  endfunction

  // Starts in IDLE at #1 after an edge, ends in the next IDLE.
  task automatic applyVec(input vec_t v);
    int n; bit gi; bit gd; int rwc;
    stall = v.stl;
    if (v.isIf) begin
      If_Addr = v.addr; If_Req = 1;
    end else begin
      Dm_RW = v.rw; Dm_BE = v.be; Dm_Addr = v.addr;
      Dm_WData = v.wd; Dm_Req = 1;
    end
    waitAck(n, gi, gd, rwc);
    chk("vec_owner", 32'({gi, gd}), v.isIf ? 32'd2 : 32'd1);
    chk("vec_latency", 32'(n), 32'(v.expN));
    chk("vec_err", 32'(v.isIf ? If_Err : Dm_Err), 32'(v.expE));
    chk("vec_rw_cycles", 32'(rwc), 32'(v.expRw));
    if (v.chkD) chk("vec_data", v.isIf ? If_Data : Dm_RData, v.expD);
    if (!v.isIf && v.rw) refWrite(v.addr, v.be, v.wd);
    If_Req = 0; Dm_Req = 0;
    @(posedge Clk); #1;
  endtask

  vec_t vt[$];

  initial begin
    logic [31:0] w22;
    int n; bit gi; bit gd; int rwc;
    bit ifP; bit dmP; int refStarve; bit expIf; bit tmo;
    logic [29:0] ia;
    int mism;

    Reset_n = 0; memInit = 1;
    If_Req = 0; If_Addr = '0;
    Dm_Req = 0; Dm_RW = 0; Dm_BE = '0; Dm_Addr = '0; Dm_WData = '0;
    for (int i = 0; i < 64; i++) refMem[i] = initVal(i);
    w22 = initVal(22);

    repeat (3) @(posedge Clk);
    #1;
    chk("reset_ctl", 32'({If_Ack, If_Err, Dm_Ack, Dm_Err, Mem_CS, Mem_RW}), 0);
    chk("reset_mem_addr", 32'({Mem_BE, Mem_Addr}), 0);
    chk("reset_mem_din", Mem_DataIn, 0);
    chk("reset_if_data", If_Data, 0);
    chk("reset_dm_rdata", Dm_RData, 0);
    memInit = 0;
    @(negedge Clk); Reset_n = 1;
    @(posedge Clk); #1;

    vt.push_back(mk(1, 0, 4'hF, 30'd7, 0, 0, 3, 1, 32'h3C08BFC0, 0, 0));
    vt.push_back(mk(0, 1, 4'hF, 30'd20, 32'hDEADBEEF, 0, 3, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 4'hF, 30'd20, 0, 0, 3, 1, 32'hDEADBEEF, 0, 0));
    vt.push_back(mk(0, 1, 4'h3, 30'd21, 32'h11223344, 0, 3, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 4'hF, 30'd21, 0, 0, 3, 1, 32'hAAAA3344, 0, 0));
    vt.push_back(mk(1, 0, 4'hF, 30'd7, 0, 3, 6, 1, 32'h3C08BFC0, 0, 0));
    vt.push_back(mk(0, 0, 4'hF, 30'h2000_0014, 0, 3, 6, 1, 32'hDEADBEEF, 0, 0));
    vt.push_back(mk(1, 0, 4'hF, 30'd9, 0, 1000, 18, 1, 32'h0, 1, 0));
    vt.push_back(mk(0, 0, 4'hF, 30'd21, 0, 1000, 18, 1, 32'h0, 1, 0));
    vt.push_back(mk(0, 0, 4'hF, 30'd20, 0, 0, 3, 1, 32'hDEADBEEF, 0, 0));
    vt.push_back(mk(1, 0, 4'hF, 30'd7, 0, TO, 3 + TO, 1, 32'h3C08BFC0, 0, 0));
    vt.push_back(mk(0, 1, 4'hC, 30'd22, 32'hCAFEF00D, 2, 5, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 4'hF, 30'd22, 0, 0, 3, 1, {16'hCAFE, w22[15:0]}, 0, 0));
    foreach (vt[i]) applyVec(vt[i]);

    // Both ports held: every (SL+1)th grant must go to fetch.
    stall = 0;
    If_Addr = 30'd7; Dm_RW = 0; Dm_BE = 4'hF; Dm_Addr = 30'd20;
    If_Req = 1; Dm_Req = 1;
    for (int k = 0; k < 10; k++) begin
      expIf = ((k + 1) % (SL + 1)) == 0;
      waitAck(n, gi, gd, rwc);
      chk("starve_grant", 32'({gi, gd}), expIf ? 32'd2 : 32'd1);
      chk("starve_latency", 32'(n), k == 0 ? 32'd3 : 32'd4);
      if (gi) chk("starve_if_data", If_Data, refMem[7]);
      if (gd) chk("starve_dm_data", Dm_RData, refMem[20]);
    end
    If_Req = 0; Dm_Req = 0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;

    // Randomized traffic against the reference model.
    ifP = 0; dmP = 0; refStarve = 0;
    for (int r = 0; r < 250 || ifP || dmP; r++) begin
      if (!ifP && r < 250 && $urandom_range(0, 1) == 1) begin
        ifP = 1; If_Addr = 30'($urandom); If_Req = 1;
      end
      if (!dmP && r < 250 && $urandom_range(0, 2) != 0) begin
        dmP = 1;
        Dm_RW = 1'($urandom_range(0, 1));
        Dm_BE = 4'($urandom);
        Dm_Addr = 30'($urandom);
        Dm_WData = $urandom;
        Dm_Req = 1;
      end
      if (!ifP && !dmP) begin
        refStarve = 0;
        @(posedge Clk); #1;
        continue;
      end
      case ($urandom_range(0, 7))
        0: stall = 1000;
        1: stall = TO;
        default: stall = $urandom_range(0, 3);
      endcase
      tmo = stall > TO;
      expIf = ifP && (!dmP || refStarve == SL);
      if (expIf) refStarve = 0;
      else if (ifP) refStarve = (refStarve < SL) ? refStarve + 1 : SL;
      else refStarve = 0;
      ia = If_Addr;
      waitAck(n, gi, gd, rwc);
      chk("rand_owner", 32'({gi, gd}), expIf ? 32'd2 : 32'd1);
      chk("rand_latency", 32'(n), tmo ? 32'(3 + TO) : 32'(3 + stall));
      if (expIf) begin
        chk("rand_if_err", 32'(If_Err), 32'(tmo));
        chk("rand_if_data", If_Data, tmo ? 32'h0 : refMem[ia[5:0]]);
        chk("rand_if_rw", 32'(rwc), 0);
      end else begin
        chk("rand_dm_err", 32'(Dm_Err), 32'(tmo));
        chk("rand_dm_rw", 32'(rwc), Dm_RW ? 32'd1 : 32'd0);
        if (Dm_RW) refWrite(Dm_Addr, Dm_BE, Dm_WData);
        else chk("rand_dm_data", Dm_RData,
                 tmo ? 32'h0 : refMem[Dm_Addr[5:0]]);
      end
      if (gi) begin If_Req = 0; ifP = 0; end
      else if (gd) begin Dm_Req = 0; dmP = 0; end
      @(posedge Clk); #1;
    end

    mism = 0;
    for (int i = 0; i < 64; i++) if (memArr[i] !== refMem[i]) mism++;
    chk("mem_image_mismatches", 32'(mism), 0);

    // Reset while a write to word 5 is in ISSUE.
    stall = 0;
    Dm_RW = 1; Dm_BE = 4'hF; Dm_Addr = 30'd5; Dm_WData = 32'h0; Dm_Req = 1;
    @(posedge Clk); #1;
    chk("issue_rw_high", 32'(Mem_RW), 1);
    Dm_Req = 0;
    #2 Reset_n = 0;
    #1;
    chk("rst_rw_drop", 32'(Mem_RW), 0);
    chk("rst_ctl", 32'({If_Ack, If_Err, Dm_Ack, Dm_Err, Mem_CS}), 0);
    chk("rst_addr_be", 32'({Mem_BE, Mem_Addr}), 0);
    chk("rst_din", Mem_DataIn, 0);
    chk("rst_if_data", If_Data, 0);
    chk("rst_dm_rdata", Dm_RData, 0);
    @(posedge Clk); #1;
    @(negedge Clk); Reset_n = 1;
    @(posedge Clk); #1;
    chk("word5_kept", memArr[5], 32'h55555555);
    chk("idle_cs_low", 32'(Mem_CS), 0);
    applyVec(mk(1, 0, 4'hF, 30'd7, 0, 0, 3, 1, 32'h3C08BFC0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer in front of the single-port `Mem` block of the MIPS CPU. It shares `Mem` between the instruction-fetch port (read-only) and the data port (read/write with byte enables). It sequences each access through issue, wait and response phases, honours `DataReady` wait states with a timeout, and stops the fetch port from starving under heavy load/store traffic. `Mem` writes on every clock edge while its `RW` input is high and ignores `CS`, so this block is the only agent that may raise `Mem_RW`.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive data-port grants allowed while a fetch is pending before the fetch port is forced to win (1..15)
- TIMEOUT, 15, WAIT cycles allowed with `Mem_DataReady` low before the access is aborted (1..255)

Ports:
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- If_Req  in  1  fetch request; held with `If_Addr` stable until `If_Ack`
- If_Addr  in  30  fetch word address [31:2]
- If_Ack  out  1  one-cycle completion pulse
- If_Data  out  32  fetched word; valid while `If_Ack`=1, held until the next fetch completes
- If_Err  out  1  timeout flag; valid with `If_Ack`
- Dm_Req  in  1  data request; held with all data-port inputs stable until `Dm_Ack`
- Dm_RW  in  1  1 = write, 0 = read
- Dm_BE  in  4  byte enables, passed through
- Dm_Addr  in  30  data word address [31:2]
- Dm_WData  in  32  write data
- Dm_Ack  out  1  one-cycle completion pulse
- Dm_RData  out  32  read data; valid with `Dm_Ack` on reads
- Dm_Err  out  1  timeout flag; valid with `Dm_Ack`
- Mem_CS, Mem_RW  out  1 each  to `Mem` CS and RW
- Mem_BE  out  4  to `Mem` BE
- Mem_Addr  out  30  to `Mem` Addr
- Mem_DataIn  out  32  to `Mem` DataIn
- Mem_DataOut  in  32  from `Mem` DataOut
- Mem_DataReady  in  1  from `Mem` DataReady

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - Samples both request lines. If neither is high, stays in IDLE.
  - Otherwise grants one port, latches that port's address, BE, RW and WData into internal registers, records the grant owner, and goes to ISSUE.
- Arbitration:
  - The data port wins by default.
  - The fetch port wins if only `If_Req` is high.
  - The fetch port also wins when both are high and `starve_cnt` == STARVE_LIMIT.
- `starve_cnt`:
  - Increments, saturating at STARVE_LIMIT, on each data grant made while `If_Req`=1.
  - Clears on any fetch grant and in any IDLE cycle with `If_Req`=0.
- ISSUE (1 cycle):
  - Drives `Mem_CS`=1 and the latched Addr/BE.
  - `Mem_RW`=1 only for a data write.
  - `Mem_DataIn` = latched WData, or 0 for reads.
  - The fetch port always uses BE 4'b1111 and RW=0.
  - Goes to WAIT.
- WAIT:
  - `Mem_CS`=1 and Addr/BE held, `Mem_RW`=0. Holding the address keeps the synchronous read result stable.
  - If `Mem_DataReady`=1: captures `Mem_DataOut` into the owner's read-data register on reads, and goes to DONE.
  - Otherwise increments `wait_cnt`. When `wait_cnt` reaches TIMEOUT, sets the error flag, loads 0 as read data, and goes to DONE.
- DONE:
  - Pulses the owner's Ack for one cycle, with Err = timeout flag.
  - Clears `wait_cnt` and the flag, then returns to IDLE.
- A request still high in the IDLE cycle after its Ack is a new access.
- A requester deasserting Req before Ack is a protocol violation; the access completes anyway.
- Simultaneous requests are resolved only in IDLE. The loser keeps waiting; it is never dropped.

## Timing
- Reset (asynchronous, immediate):
  - FSM goes to IDLE; counters and latches clear.
  - All outputs are 0: Acks, Errs, `Mem_CS`, `Mem_RW`, `Mem_BE`, `Mem_Addr`, `Mem_DataIn`, `If_Data`, `Dm_RData`.
  - Reset during ISSUE of a write must drop `Mem_RW` combinationally from state, so no write occurs at the next edge.
- Mem outputs are decoded from registered state. `Mem_RW` is never high outside ISSUE.
- Latency with `Mem_DataReady` tied to 1: Req sampled in IDLE at cycle 0, ISSUE at cycle 1, WAIT at cycle 2, Ack at cycle 3. Each access occupies 4 cycles including IDLE.
- Back-to-back throughput: one access per 4 cycles.
- Each extra `Mem_DataReady`=0 cycle in WAIT adds 1 cycle.
- Worst case to Ack: 3 + TIMEOUT cycles.
- If/Dm read-data registers update only in WAIT of their own accesses and hold otherwise.

## Test plan
- Fetch only, `If_Addr`=7, `Mem` preloaded with 0x3C08BFC0 at word 7 -> `If_Ack` at cycle 3, `If_Data`=0x3C08BFC0, `If_Err`=0, `Mem_RW` 0 throughout.
- Data write to word 20 with data 0xDEADBEEF and BE 4'b1111, then data read of word 20 -> `Dm_RData`=0xDEADBEEF. `Mem_RW`=1 for exactly one cycle.
- Both Reqs held continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; no Ack is lost.
- `Mem_DataReady` low for 3 WAIT cycles -> Ack at cycle 6 with correct data. Held low permanently with TIMEOUT=15 -> Ack at cycle 18 with Err=1 and data 0, after which the FSM accepts a new request.
- Reset_n pulsed low during ISSUE of a write to word 5 -> `Mem_RW` drops immediately, word 5 is unchanged, all outputs are 0, and the FSM is in IDLE after reset release.
